imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the decode-side immediate extraction: takes an opcode, register fields, a 32-bit immediate and a format select, and packs them into a 32-bit RV32I instruction word.
- Flags immediates that the selected format cannot represent.
- Expands the load-immediate pseudo-op into one or two instructions (ADDI and/or LUI).
- Serves the self-test instruction generator and the boot-ROM patcher; sits between a request producer and instruction memory write logic via valid/ready.

Parameters:
- LI_SUPPORT, 1, 1 = pseudo-op expansion enabled; 0 = req_li ignored, request treated as a normal encode.
- NOP_INSTR, 32'h0000_0013, word emitted for an illegal format select.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_extop  in  3  format: 000 I, 001 U, 010 S, 011 B, 100 J, others illegal
- req_opcode  in  7  instr[6:0]
- req_funct3  in  3  instr[14:12]
- req_rd  in  5  destination register
- req_rs1  in  5  source 1
- req_rs2  in  5  source 2
- req_imm  in  32  immediate value (byte offset for B/J; full value for U, low 12 bits must be 0)
- req_li  in  1  load-immediate pseudo-op: rd <- req_imm; extop/opcode/funct3/rs ignored
- out_valid  out  1  instruction word valid
- out_ready  in  1  consumer accepts
- out_instr  out  32  encoded instruction
- out_err  out  1  immediate not representable; fields truncated anyway

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out_instr=0, out_err=0, FSM=IDLE, req_ready=0 during reset. Reset mid-expansion drops any pending second instruction.
- Output register: holds out_instr/out_err stable while out_valid && !out_ready.
- req_ready = (state==IDLE) && (!out_valid || out_ready).
- Latency: request accepted at edge N -> out_valid=1 after edge N, one word per handshake.
- Encoding:
  - I = imm[11:0],rs1,f3,rd,op.
  - S = imm[11:5],rs2,rs1,f3,imm[4:0],op.
  - B = imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op.
  - U = imm[31:12],rd,op.
  - J = imm[20],imm[10:1],imm[11],imm[19:12],rd,op.
- Error rules:
  - I/S: imm not equal to sign-extension of imm[11:0].
  - B: imm[0]=1 or imm not 13-bit signed.
  - J: imm[0]=1 or imm not 21-bit signed.
  - U: imm[11:0]!=0.
  - Illegal extop: out_instr=NOP_INSTR, out_err=1.
- LI expansion (LI_SUPPORT=1), by req_imm:
  - Fits 12-bit signed: emit ADDI rd,x0,imm[11:0].
  - imm[11:0]==0: emit LUI rd,imm[31:12].
  - Otherwise: emit LUI rd,hi where hi=(imm+32'h800)[31:12], then ADDI rd,rd,imm[11:0].
  - out_err is always 0 for LI.
  - rd==0 is still encoded.
- FSM states:
  - IDLE: accepting requests.
  - LI_HI: LUI word presented, ADDI pending. Enter from IDLE when the two-word LI case is accepted.
  - In LI_HI, when out_ready=1 the ADDI word loads the output register the same edge and state returns to IDLE.
  - req_ready stays 0 in LI_HI.
- Back-to-back: with out_ready tied 1, one instruction word per cycle, no bubbles (including LUI->ADDI).

Optional Feature:
- Macro IMM_ENC_STATS_EN.
- When defined: adds outputs stat_words[15:0] (count of out handshakes) and stat_errs[15:0] (handshakes with out_err=1).
  - Both saturate at 16'hFFFF.
  - Both cleared by reset.
- When undefined: ports and counters absent, behaviour otherwise identical.

Decomposition:
- Shared package imm_pkg:
  - Format-select constants (IMM_I=3'b000, IMM_U=3'b001, IMM_S=3'b010, IMM_B=3'b011, IMM_J=3'b100), shared with the decode-side immediate generator.
  - Opcode constants OP_LUI=7'b0110111, OP_OPIMM=7'b0010011.
  - FSM state enum.
- One natural sub-module: imm_pack, purely combinational field packing plus range check (inputs extop/fields/imm -> instr, err). imm_encoder owns the FSM, handshake and output register.

Test Plan:
- I encode: extop=000, op=0x13, f3=0, rd=5, rs1=0, imm=32'hFFFFFFFF -> out_instr=32'hFFF00293, err=0, valid one cycle after accept.
- B encode: op=0x63, rs1=1, rs2=2, imm=8 -> 32'h00208463. Same with imm=3 -> err=1.
- J encode: op=0x6F, rd=1, imm=32'h800 -> 32'h001000EF. imm=32'h00100000 -> err=1.
- LI two-word: rd=1, imm=32'h12345678 -> 32'h123450B7 then 32'h67808093. req_ready=0 between.
  - Same for rd=2, imm=32'h00000FFF -> 32'h00001137 then 32'hFFF10113.
  - Single-word cases: imm=-5 -> single ADDI; imm=32'h00010000 -> single LUI.
- Backpressure/reset: hold out_ready=0 for 3 cycles -> out_instr/out_valid stable, req_ready=0. Assert rst_n=0 while in LI_HI -> next cycle out_valid=0, state IDLE, no ADDI emitted.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// Shared constants and types for the immediate encoder.
// Format-select values are shared with the decode-side immediate generator.
package imm_pkg;

  // Format selects
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_U = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // Opcodes used by the load-immediate expansion
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_OPIMM = 7'b0010011;

  // Encoder FSM: IDLE accepts requests, LI_HI holds the pending ADDI
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_LI_HI = 1'b1
  } enc_state_e;

  // One output word and its error flag
  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_word_t;

  // True when v is the sign extension of its low 'bits' bits
  function automatic logic fits_signed(input logic [31:0] v, input int bits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++)
      if (i >= bits && v[i] != v[bits-1]) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational RV32I field packing plus immediate range check.
// An illegal format select yields NOP_INSTR with err set.
module imm_pack
  import imm_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic [2:0]  extop,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  // Pack fields by format; out-of-range immediates are truncated but flagged
  always_comb begin
    instr = NOP_INSTR;
    err   = 1'b1;
    case (extop)
      IMM_I: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        err   = !fits_signed(imm, 12);
      end
      IMM_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err   = !fits_signed(imm, 12);
      end
      IMM_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err   = imm[0] || !fits_signed(imm, 13);
      end
      IMM_U: begin
        instr = {imm[31:12], rd, opcode};
        err   = (imm[11:0] != 12'd0);
      end
      IMM_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err   = imm[0] || !fits_signed(imm, 21);
      end
      default: begin
        instr = NOP_INSTR;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: packs request fields into RV32I words behind a
// valid/ready handshake, expanding the load-immediate pseudo-op into
// ADDI and/or LUI. Optional stats counters under IMM_ENC_STATS_EN.
module imm_encoder
  import imm_pkg::*;
#(
  parameter bit          LI_SUPPORT = 1'b1,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_extop,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  input  logic        req_li,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
`ifdef IMM_ENC_STATS_EN
  output logic [15:0] stat_words,
  output logic [15:0] stat_errs,
`endif
  output logic        out_err
);

  enc_state_e  state;
  logic [31:0] addi_q;
  logic [31:0] pk_instr;
  logic        pk_err;
  logic        accept;
  logic        out_hs;
  enc_word_t   first_w;
  logic        two_word;
  logic [31:0] addi_nxt;
  logic [19:0] li_hi;

  imm_pack #(.NOP_INSTR(NOP_INSTR)) u_pack (
    .extop  (req_extop),
    .opcode (req_opcode),
    .funct3 (req_funct3),
    .rd     (req_rd),
    .rs1    (req_rs1),
    .rs2    (req_rs2),
    .imm    (req_imm),
    .instr  (pk_instr),
    .err    (pk_err)
  );

  assign req_ready = rst_n && (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = req_valid && req_ready;
  assign out_hs    = out_valid && out_ready;

  // LUI upper part rounds up when ADDI's sign-extended low half is negative
  assign li_hi    = req_imm[31:12] + {19'd0, req_imm[11]};
  assign addi_nxt = {req_imm[11:0], req_rd, 3'b000, req_rd, OP_OPIMM};

  // Select the first word to emit and whether an ADDI must follow
  always_comb begin
    first_w  = '{instr: pk_instr, err: pk_err};
    two_word = 1'b0;
    if (LI_SUPPORT && req_li) begin
      if (fits_signed(req_imm, 12)) begin
        first_w = '{instr: {req_imm[11:0], 5'd0, 3'b000, req_rd, OP_OPIMM}, err: 1'b0};
      end else if (req_imm[11:0] == 12'd0) begin
        first_w = '{instr: {req_imm[31:12], req_rd, OP_LUI}, err: 1'b0};
      end else begin
        first_w  = '{instr: {li_hi, req_rd, OP_LUI}, err: 1'b0};
        two_word = 1'b1;
      end
    end
  end

  // Output register and FSM; the pending ADDI replaces LUI on its handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_err   <= 1'b0;
      addi_q    <= 32'd0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_instr <= first_w.instr;
      out_err   <= first_w.err;
      if (two_word) begin
        state  <= ST_LI_HI;
        addi_q <= addi_nxt;
      end
    end else if (out_hs) begin
      if (state == ST_LI_HI) begin
        out_instr <= addi_q;
        out_err   <= 1'b0;
        state     <= ST_IDLE;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef IMM_ENC_STATS_EN
  // Saturating counts of output handshakes and of flagged words
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_words <= 16'd0;
      stat_errs  <= 16'd0;
    end else if (out_hs) begin
      if (stat_words != 16'hFFFF) stat_words <= stat_words + 16'd1;
      if (out_err && stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: scoreboard of expected words built
// from an arithmetic model, checked every cycle, plus literal pins.
module tb_imm_encoder;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_extop = '0;
  logic [6:0]  req_opcode = '0;
  logic [2:0]  req_funct3 = '0;
  logic [4:0]  req_rd = '0;
  logic [4:0]  req_rs1 = '0;
  logic [4:0]  req_rs2 = '0;
  logic [31:0] req_imm = '0;
  logic        req_li = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_err;
`ifdef IMM_ENC_STATS_EN
  logic [15:0] stat_words;
  logic [15:0] stat_errs;
`endif

  always #5 clk = ~clk;

  imm_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_extop(req_extop), .req_opcode(req_opcode), .req_funct3(req_funct3),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_imm(req_imm), .req_li(req_li),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
`ifdef IMM_ENC_STATS_EN
    .stat_words(stat_words), .stat_errs(stat_errs),
`endif
    .out_err(out_err)
  );

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int err_cnt = 0;
  bit mon_en = 1'b0;
  bit rnd_rdy = 1'b0;

  typedef struct {
    bit [31:0] w;
    bit        e;
  } exp_t;
  exp_t q[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference encoding from the format definitions, using plain arithmetic
  function automatic void model_enc(input bit [2:0] x, input bit [31:0] op, f3, rd, rs1, rs2, imm,
                                    output bit [31:0] w, output bit e);
    int si;
    si = signed'(imm);
    case (x)
      3'd0: begin
        w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        e = (si < -2048) || (si > 2047);
      end
      3'd2: begin
        w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
          | ((imm & 32'h1F) << 7) | op;
        e = (si < -2048) || (si > 2047);
      end
      3'd3: begin
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
          | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | op;
        e = (imm % 2 != 0) || (si < -4096) || (si > 4095);
      end
      3'd1: begin
        w = (imm & 32'hFFFFF000) | (rd << 7) | op;
        e = (imm % 4096) != 0;
      end
      3'd4: begin
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
          | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
        e = (imm % 2 != 0) || (si < -1048576) || (si > 1048575);
      end
      default: begin
        w = 32'h0000_0013;
        e = 1'b1;
      end
    endcase
  endfunction

  // Push the expected word(s) for one accepted request
  function automatic void model_push(input bit [2:0] x, input bit [31:0] op, f3, rd, rs1, rs2, imm, input bit li);
    exp_t t;
    int si;
    bit [31:0] hi;
    si = signed'(imm);
    t.e = 1'b0;
    if (li) begin
      if (si >= -2048 && si <= 2047) begin
        t.w = ((imm & 32'hFFF) << 20) | (rd << 7) | 32'h13;
        q.push_back(t);
      end else if ((imm & 32'hFFF) == 0) begin
        t.w = (imm & 32'hFFFFF000) | (rd << 7) | 32'h37;
        q.push_back(t);
      end else begin
        hi = (imm + 32'h800) & 32'hFFFFF000;
        t.w = hi | (rd << 7) | 32'h37;
        q.push_back(t);
        t.w = ((imm & 32'hFFF) << 20) | (rd << 15) | (rd << 7) | 32'h13;
        q.push_back(t);
      end
    end else begin
      model_enc(x, op, f3, rd, rs1, rs2, imm, t.w, t.e);
      q.push_back(t);
    end
  endfunction

  // Per-cycle compare: valid, word, error and ready against the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        chk("ready_in_reset", 32'(req_ready), 32'd0);
        q.delete();
        hs_cnt  = 0;
        err_cnt = 0;
      end else begin
        chk("valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
          chk("instr", out_instr, q[0].w);
          chk("err", 32'(out_err), 32'(q[0].e));
        end
        chk("req_ready", 32'(req_ready),
            32'(q.size() < 2 && (q.size() == 0 || out_ready)));
        if (out_valid && out_ready && q.size() != 0) begin
          hs_cnt++;
          if (q[0].e) err_cnt++;
          void'(q.pop_front());
        end
        if (req_valid && req_ready)
          model_push(req_extop, 32'(req_opcode), 32'(req_funct3), 32'(req_rd), 32'(req_rs1),
                     32'(req_rs2), req_imm, req_li);
      end
    end
  end

  // Random backpressure during the random phase
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = ($urandom % 4) != 0;
    end
  end

  // Drive one request and wait (bounded) for its acceptance edge
  task automatic send(input bit [2:0] x, input bit [6:0] op, input bit [2:0] f3,
                      input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                      input bit [31:0] imm, input bit li);
    bit acc;
    req_extop = x; req_opcode = op; req_funct3 = f3; req_rd = rd;
    req_rs1 = rs1; req_rs2 = rs2; req_imm = imm; req_li = li;
    req_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        req_valid = 1'b0;
        return;
      end
    end
    req_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL send_timeout: request not accepted within 200 cycles");
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit [31:0] w;
    bit        e;
    int        r;
    bit [31:0] imm;
    bit [2:0]  x;

    // Hand-computed pins for the model itself
    model_enc(3'd0, 32'h13, 0, 5, 0, 0, 32'hFFFFFFFF, w, e);
    chk("pin_I_word", w, 32'hFFF00293); chk("pin_I_err", 32'(e), 32'd0);
    model_enc(3'd3, 32'h63, 0, 0, 1, 2, 32'd8, w, e);
    chk("pin_B_word", w, 32'h00208463); chk("pin_B_err", 32'(e), 32'd0);
    model_enc(3'd3, 32'h63, 0, 0, 1, 2, 32'd3, w, e);
    chk("pin_B_odd_err", 32'(e), 32'd1);
    model_enc(3'd4, 32'h6F, 0, 1, 0, 0, 32'h800, w, e);
    chk("pin_J_word", w, 32'h001000EF); chk("pin_J_err", 32'(e), 32'd0);
    model_enc(3'd4, 32'h6F, 0, 1, 0, 0, 32'h00100000, w, e);
    chk("pin_J_range_err", 32'(e), 32'd1);

    // Reset state
    @(posedge clk); #1; mon_en = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // I encode, one cycle latency
    send(3'd0, 7'h13, 3'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0);
    chk("I_valid_after_accept", 32'(out_valid), 32'd1);
    chk("I_word", out_instr, 32'hFFF00293);
    tick();
    // B and J encodes, legal and flagged
    send(3'd3, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    chk("B_word", out_instr, 32'h00208463);
    send(3'd3, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0);
    chk("B_odd_err", 32'(out_err), 32'd1);
    send(3'd4, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h800, 1'b0);
    chk("J_word", out_instr, 32'h001000EF);
    send(3'd4, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00100000, 1'b0);
    chk("J_range_err", 32'(out_err), 32'd1);
    send(3'd6, 7'h33, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    chk("illegal_nop", out_instr, 32'h0000_0013);
    chk("illegal_err", 32'(out_err), 32'd1);
    tick();

    // LI two-word, back to back
    send(3'd0, 7'h0, 3'd0, 5'd1, 5'd0, 5'd0, 32'h12345678, 1'b1);
    chk("LI_lui", out_instr, 32'h123450B7);
    chk("LI_ready_low", 32'(req_ready), 32'd0);
    tick();
    chk("LI_addi", out_instr, 32'h67808093);
    send(3'd0, 7'h0, 3'd0, 5'd2, 5'd0, 5'd0, 32'h00000FFF, 1'b1);
    chk("LI2_lui", out_instr, 32'h00001137);
    tick();
    chk("LI2_addi", out_instr, 32'hFFF10113);
    send(3'd0, 7'h0, 3'd0, 5'd3, 5'd0, 5'd0, 32'hFFFFFFFB, 1'b1);
    chk("LI_addi_only", out_instr, 32'hFFB00193);
    send(3'd0, 7'h0, 3'd0, 5'd4, 5'd0, 5'd0, 32'h00010000, 1'b1);
    chk("LI_lui_only", out_instr, 32'h00010237);
    tick(); tick();

    // Backpressure holds the word
    out_ready = 1'b0;
    send(3'd2, 7'h23, 3'd2, 5'd0, 5'd7, 5'd9, 32'hFFFFFFF0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();

    // Reset while the ADDI is pending
    out_ready = 1'b0;
    send(3'd0, 7'h0, 3'd0, 5'd1, 5'd0, 5'd0, 32'h12345678, 1'b1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_instr", out_instr, 32'd0);
    tick();
    chk("midrst_no_addi", 32'(out_valid), 32'd0);

    // Randomized traffic with random backpressure
    rnd_rdy = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 2);
      for (int g = 0; g < r; g++) tick();
      case ($urandom % 4)
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: imm = $urandom & 32'hFFFFF000;
        default: imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'($urandom % 2);
      endcase
      x = ($urandom % 8 == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      send(x, 7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           imm, ($urandom % 4) == 0);
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
`ifdef IMM_ENC_STATS_EN
    chk("stat_words", 32'(stat_words), 32'(hs_cnt));
    chk("stat_errs", 32'(stat_errs), 32'(err_cnt));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
